// File: rtl/flight_sequencer_pkg.sv
// flight_sequencer_pkg: shared state encodings, fault codes and default thresholds
//   for the drone2 arming sequencer and its millisecond tick divider.
package flight_sequencer_pkg;

    typedef enum logic [2:0] {
        FS_DISARMED   = 3'd0,
        FS_ARM_WAIT   = 3'd1,
        FS_ARMED_IDLE = 3'd2,
        FS_WAIT_AC    = 3'd3,
        FS_WAIT_BF    = 3'd4,
        FS_FAILSAFE   = 3'd5
    } fs_state_t;

    localparam logic [1:0] FAULT_NONE = 2'b00;
    localparam logic [1:0] FAULT_IMU  = 2'b01;
    localparam logic [1:0] FAULT_AC   = 2'b10;
    localparam logic [1:0] FAULT_BF   = 2'b11;

    localparam int DEF_REC_WIDTH         = 8;
    localparam int DEF_CLK_PER_MS        = 38000;
    localparam int DEF_ARM_HOLD_MS       = 500;
    localparam int DEF_IMU_TIMEOUT_MS    = 50;
    localparam int DEF_STAGE_TIMEOUT_CYC = 4096;
    localparam int DEF_THROTTLE_IDLE_MAX = 10;
    localparam int DEF_ARM_THRESH        = 128;

endpackage

// File: rtl/flight_sequencer_ms_tick.sv
// ms_tick_gen: free-running divider producing a one-cycle ms_tick every CLK_PER_MS cycles.
//   sys_clk  in   system clock
//   resetn   in   synchronous active-low reset
//   ms_tick  out  registered pulse, high for one cycle after the counter wraps
module ms_tick_gen
    import flight_sequencer_pkg::*;
#(
    parameter int CLK_PER_MS = DEF_CLK_PER_MS
) (
    input  logic sys_clk,
    input  logic resetn,
    output logic ms_tick
);

    localparam int W = (CLK_PER_MS > 1) ? $clog2(CLK_PER_MS) : 1;

    logic [W-1:0] cnt;
    logic         wrap;

    assign wrap = cnt == W'(CLK_PER_MS - 1);

    always_ff @(posedge sys_clk) begin
        if (!resetn) begin
            cnt     <= '0;
            ms_tick <= 1'b0;
        end else begin
            ms_tick <= wrap;
            cnt     <= wrap ? '0 : cnt + 1'b1;
        end
    end

endmodule

// File: rtl/flight_sequencer.sv
// flight_sequencer: arm/disarm FSM and per-IMU-sample control-pass scheduler with stage watchdogs.
//   sys_clk, resetn            clock and synchronous active-low reset
//   imu_good, imu_valid_strobe IMU health flag and data-valid level (rising edge = new sample)
//   ac_complete, bf_complete   done pulses from angle / body-frame controllers
//   throttle_val, arm_val      receiver throttle and aux1 arm switch
//   ac_start, bf_start         one-cycle controller start pulses
//   mix_latch                  one-cycle motor_mixer latch pulse
//   motor_enable               PWM allowed
//   failsafe, fault_code       latched fault flag and cause
//   state_out                  current state encoding for debug LEDs
module flight_sequencer
    import flight_sequencer_pkg::*;
#(
    parameter int REC_WIDTH         = DEF_REC_WIDTH,
    parameter int CLK_PER_MS        = DEF_CLK_PER_MS,
    parameter int ARM_HOLD_MS       = DEF_ARM_HOLD_MS,
    parameter int IMU_TIMEOUT_MS    = DEF_IMU_TIMEOUT_MS,
    parameter int STAGE_TIMEOUT_CYC = DEF_STAGE_TIMEOUT_CYC,
    parameter int THROTTLE_IDLE_MAX = DEF_THROTTLE_IDLE_MAX,
    parameter int ARM_THRESH        = DEF_ARM_THRESH
) (
    input  logic                 sys_clk,
    input  logic                 resetn,
    input  logic                 imu_good,
    input  logic                 imu_valid_strobe,
    input  logic                 ac_complete,
    input  logic                 bf_complete,
    input  logic [REC_WIDTH-1:0] throttle_val,
    input  logic [REC_WIDTH-1:0] arm_val,
    output logic                 ac_start,
    output logic                 bf_start,
    output logic                 mix_latch,
    output logic                 motor_enable,
    output logic                 failsafe,
    output logic [1:0]           fault_code,
    output logic [2:0]           state_out
);

    localparam int HOLD_W = $clog2(ARM_HOLD_MS + 1);
    localparam int WD_W   = $clog2(IMU_TIMEOUT_MS + 1);
    localparam int STG_W  = $clog2(STAGE_TIMEOUT_CYC + 1);

    fs_state_t         state;
    logic [HOLD_W-1:0] hold_cnt;
    logic [WD_W-1:0]   wd_cnt;
    logic [STG_W-1:0]  stage_cnt;
    logic              ms_tick;
    logic              imu_d1;
    logic              imu_edge;
    logic              arm_req;
    logic              throttle_idle;
    logic              arm_ok;
    logic              stage_expired;
    logic [1:0]        fault_sel;

    assign arm_req       = arm_val >= REC_WIDTH'(ARM_THRESH);
    assign throttle_idle = throttle_val <= REC_WIDTH'(THROTTLE_IDLE_MAX);
    assign arm_ok        = arm_req & throttle_idle & imu_good;
    assign state_out     = state;

    // Timeouts compare the pre-increment count, so a completion arriving in the
    // same cycle the counter hits its limit loses to the fault.
    assign stage_expired = stage_cnt >= STG_W'(STAGE_TIMEOUT_CYC);
    assign fault_sel     = (!imu_good || wd_cnt >= WD_W'(IMU_TIMEOUT_MS)) ? FAULT_IMU :
                           (stage_expired && state == FS_WAIT_AC)         ? FAULT_AC  :
                           (stage_expired && state == FS_WAIT_BF)         ? FAULT_BF  :
                                                                            FAULT_NONE;

    ms_tick_gen #(
        .CLK_PER_MS(CLK_PER_MS)
    ) u_ms_tick (
        .sys_clk(sys_clk),
        .resetn (resetn),
        .ms_tick(ms_tick)
    );

    always_ff @(posedge sys_clk) begin
        if (!resetn) begin
            state        <= FS_DISARMED;
            hold_cnt     <= '0;
            wd_cnt       <= '0;
            stage_cnt    <= '0;
            imu_d1       <= 1'b0;
            imu_edge     <= 1'b0;
            ac_start     <= 1'b0;
            bf_start     <= 1'b0;
            mix_latch    <= 1'b0;
            motor_enable <= 1'b0;
            failsafe     <= 1'b0;
            fault_code   <= FAULT_NONE;
        end else begin
            imu_d1    <= imu_valid_strobe;
            imu_edge  <= imu_valid_strobe & ~imu_d1;
            ac_start  <= 1'b0;
            bf_start  <= 1'b0;
            mix_latch <= 1'b0;
            case (state)
                FS_DISARMED: begin
                    hold_cnt <= '0;
                    if (arm_ok) state <= FS_ARM_WAIT;
                end
                FS_ARM_WAIT: begin
                    if (!arm_ok) begin
                        state    <= FS_DISARMED;
                        hold_cnt <= '0;
                    end else if (hold_cnt >= HOLD_W'(ARM_HOLD_MS)) begin
                        state        <= FS_ARMED_IDLE;
                        motor_enable <= 1'b1;
                        hold_cnt     <= '0;
                        wd_cnt       <= '0;
                        stage_cnt    <= '0;
                    end else if (ms_tick) begin
                        hold_cnt <= hold_cnt + 1'b1;
                    end
                end
                FS_FAILSAFE: begin
                    if (!arm_req && throttle_idle) begin
                        state      <= FS_DISARMED;
                        failsafe   <= 1'b0;
                        fault_code <= FAULT_NONE;
                    end
                end
                // Armed states: disarm beats fault beats progress.
                default: begin
                    if (!arm_req) begin
                        state        <= FS_DISARMED;
                        motor_enable <= 1'b0;
                        wd_cnt       <= '0;
                        stage_cnt    <= '0;
                    end else if (fault_sel != FAULT_NONE) begin
                        state        <= FS_FAILSAFE;
                        motor_enable <= 1'b0;
                        failsafe     <= 1'b1;
                        fault_code   <= fault_sel;
                        wd_cnt       <= '0;
                        stage_cnt    <= '0;
                    end else begin
                        // Any IMU edge feeds the watchdog, even one dropped mid-pass.
                        wd_cnt <= imu_edge ? '0 : wd_cnt + WD_W'(ms_tick);
                        if (state == FS_ARMED_IDLE && imu_edge) begin
                            state     <= FS_WAIT_AC;
                            ac_start  <= 1'b1;
                            stage_cnt <= '0;
                        end else if (state == FS_WAIT_AC && ac_complete) begin
                            state     <= FS_WAIT_BF;
                            bf_start  <= 1'b1;
                            stage_cnt <= '0;
                        end else if (state == FS_WAIT_BF && bf_complete) begin
                            state     <= FS_ARMED_IDLE;
                            mix_latch <= 1'b1;
                            stage_cnt <= '0;
                        end else if (state != FS_ARMED_IDLE) begin
                            stage_cnt <= stage_cnt + 1'b1;
                        end
                    end
                end
            endcase
        end
    end

endmodule
